// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter slice.
// Holds the pipeline OP encodings, the read-return owner tag, the
// arbitration state names and default memory geometry.
package dmem_pkg;

    localparam int DMEM_ADDR_W       = 7;
    localparam int DMEM_DATA_W       = 16;
    localparam int DMEM_STARVE_LIMIT = 4;

    // Pipeline MEM-stage operation codes (2'b0x means no memory access)
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    // Which port the data returned next cycle belongs to
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_P0   = 2'd1,
        OWN_P1   = 2'd2
    } rd_owner_e;

    // NORMAL: port 0 has priority; FORCED: port 1 has aged out and must win
    typedef enum logic {
        ARB_NORMAL = 1'b0,
        ARB_FORCED = 1'b1
    } arb_state_e;

    // Port 0 wants the memory whenever the top OP bit is set
    function automatic logic op_is_access(input logic [1:0] op);
        return op[1];
    endfunction

    // Store when the access flag and the store-select bit are both set
    function automatic logic op_is_store(input logic [1:0] op);
        return (op == OP_STORE);
    endfunction

endpackage

// File: rtl/dmem_age_counter.sv
// Saturating age counter protecting port 1 from starvation.
// Ports:
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset (count -> 0)
//   clear_i  clear the count this cycle (port 1 idle or granted)
//   inc_i    count one more denied cycle (ignored while clear_i)
//   force_o  count has reached STARVE_LIMIT; port 1 must win
module dmem_age_counter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic force_o
);

    localparam int AGE_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

    logic [AGE_W-1:0] age_q;
    logic [AGE_W-1:0] age_d;

    // Next count: clear wins, otherwise saturate at the limit
    always_comb begin
        age_d = age_q;
        if (clear_i) begin
            age_d = '0;
        end else if (inc_i && (age_q != AGE_MAX)) begin
            age_d = age_q + AGE_W'(1);
        end else begin
            age_d = age_q;
        end
    end

    // Count register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    // A zero limit means port 1 always has priority, so force is constant
    generate
        if (STARVE_LIMIT == 0) begin : g_strict
            assign force_o = 1'b1;
        end else begin : g_aged
            // The count saturates, so equality is the same as reaching the limit
            assign force_o = (age_q == AGE_MAX);
        end
    endgenerate

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 128x16 data memory.
// Port 0 (pipeline MEM stage, OP-encoded) has default priority; port 1
// (loader/debug, valid/grant) wins when port 0 is idle or when it has been
// denied STARVE_LIMIT cycles in a row. Read data returns one cycle after
// the granted read, tagged to the port that issued it.
// Ports:
//   CLOCK_50, RESET                  clock, synchronous active-high reset
//   P0_OP/P0_ADDR/P0_WDATA           port 0 request
//   P0_STALL/P0_RVALID/P0_RDATA      port 0 stall and load return
//   P1_REQ/P1_WE/P1_ADDR/P1_WDATA    port 1 request
//   P1_GNT/P1_RVALID/P1_RDATA        port 1 grant and read return
//   MEM_EN/MEM_WE/MEM_ADDR/MEM_WDATA memory command
//   MEM_RDATA                        memory read data (1-cycle latency)
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W       = DMEM_ADDR_W,
    parameter int DATA_W       = DMEM_DATA_W,
    parameter int STARVE_LIMIT = DMEM_STARVE_LIMIT
) (
    input  logic              CLOCK_50,
    input  logic              RESET,
    input  logic [1:0]        P0_OP,
    input  logic [15:0]       P0_ADDR,
    input  logic [DATA_W-1:0] P0_WDATA,
    output logic              P0_STALL,
    output logic              P0_RVALID,
    output logic [DATA_W-1:0] P0_RDATA,
    input  logic              P1_REQ,
    input  logic              P1_WE,
    input  logic [15:0]       P1_ADDR,
    input  logic [DATA_W-1:0] P1_WDATA,
    output logic              P1_GNT,
    output logic              P1_RVALID,
    output logic [DATA_W-1:0] P1_RDATA,
    output logic              MEM_EN,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    // Requests are masked during reset so every output reads 0 then
    logic       p0_req_s;
    logic       p1_req_s;
    logic       force_s;
    arb_state_e arb_state_s;
    logic       p1_win_s;
    logic       p0_win_s;
    rd_owner_e  rd_owner_q;
    rd_owner_e  rd_owner_d;

    // Upper address bits are deliberately ignored
    logic unused_addr_s;
    assign unused_addr_s = ^{P0_ADDR[15:ADDR_W], P1_ADDR[15:ADDR_W]};

    // Request decode and arbitration
    always_comb begin
        p0_req_s    = ~RESET & op_is_access(P0_OP);
        p1_req_s    = ~RESET & P1_REQ;
        arb_state_s = force_s ? ARB_FORCED : ARB_NORMAL;
        p1_win_s    = p1_req_s & (~p0_req_s | (arb_state_s == ARB_FORCED));
        p0_win_s    = p0_req_s & ~p1_win_s;
    end

    // Age resets whenever port 1 is idle or served; counts denied cycles
    dmem_age_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_age (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .clear_i (~p1_req_s | p1_win_s),
        .inc_i   (p1_req_s),
        .force_o (force_s)
    );

    // Memory command mux driven by the winner; all zero when nobody wins
    always_comb begin
        MEM_EN    = 1'b0;
        MEM_WE    = 1'b0;
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        if (p1_win_s) begin
            MEM_EN    = 1'b1;
            MEM_WE    = P1_WE;
            MEM_ADDR  = P1_ADDR[ADDR_W-1:0];
            MEM_WDATA = P1_WDATA;
        end else if (p0_win_s) begin
            MEM_EN    = 1'b1;
            MEM_WE    = op_is_store(P0_OP);
            MEM_ADDR  = P0_ADDR[ADDR_W-1:0];
            MEM_WDATA = P0_WDATA;
        end else begin
            MEM_EN    = 1'b0;
        end
    end

    // Handshake outputs; stall only ever accompanies a port 0 request
    always_comb begin
        P1_GNT   = p1_win_s;
        P0_STALL = p0_req_s & p1_win_s;
    end

    // Tag the granted read so its data is routed back next cycle
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (p1_win_s && !P1_WE) begin
            rd_owner_d = OWN_P1;
        end else if (p0_win_s && !op_is_store(P0_OP)) begin
            rd_owner_d = OWN_P0;
        end else begin
            rd_owner_d = OWN_NONE;
        end
    end

    // Read-owner tag register (one entry, never blocks)
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            rd_owner_q <= OWN_NONE;
        end else begin
            rd_owner_q <= rd_owner_d;
        end
    end

    // Return routing; a return pending when reset arrives is dropped
    always_comb begin
        P0_RVALID = ~RESET & (rd_owner_q == OWN_P0);
        P1_RVALID = ~RESET & (rd_owner_q == OWN_P1);
        P0_RDATA  = P0_RVALID ? MEM_RDATA : '0;
        P1_RDATA  = P1_RVALID ? MEM_RDATA : '0;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 128x16 data memory between two requesters.
- Port 0 is the pipeline MEM stage, which uses the 2-bit OP encoding. Port 1 is a loader/debug port using a valid/grant handshake.
- Port 0 has default priority. Port 1 is protected from starvation by an age counter; when it wins, the arbiter stalls the pipeline.
- Sits between the MEM stage and the data memory array and owns all memory port signals.

Parameters:
- ADDR_W, 7, memory address width; low ADDR_W bits of the 16-bit request address are used, upper bits are ignored.
- DATA_W, 16, data word width.
- STARVE_LIMIT, 4, consecutive denied cycles after which port 1 is forced to win; 0 means port 1 has strict priority.

Ports:
- CLOCK_50  in  1  sole clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- P0_OP  in  2  pipeline op: 2'b10 load, 2'b11 store, 2'b0x no memory access.
- P0_ADDR  in  16  port 0 address.
- P0_WDATA  in  DATA_W  port 0 store data.
- P0_STALL  out  1  port 0 request not served this cycle; pipeline holds its inputs.
- P0_RVALID  out  1  port 0 load data valid.
- P0_RDATA  out  DATA_W  port 0 load data.
- P1_REQ  in  1  port 1 request valid.
- P1_WE  in  1  port 1 write (1) / read (0).
- P1_ADDR  in  16  port 1 address.
- P1_WDATA  in  DATA_W  port 1 write data.
- P1_GNT  out  1  port 1 request accepted this cycle.
- P1_RVALID  out  1  port 1 read data valid.
- P1_RDATA  out  DATA_W  port 1 read data.
- MEM_EN  out  1  memory access this cycle.
- MEM_WE  out  1  memory write.
- MEM_ADDR  out  ADDR_W  memory address.
- MEM_WDATA  out  DATA_W  memory write data.
- MEM_RDATA  in  DATA_W  memory read data, valid one cycle after a read access.

Behaviour:
- Port 0 requests when P0_OP[1]=1; P0_OP[0] selects store.
- Port 1 requests when P1_REQ=1. Its transfer completes in the cycle with P1_REQ && P1_GNT. The requester holds address, data and WE stable until granted.
- Arbitration is combinational each cycle from the requests plus the registered age count AGE.
  - FORCE = (AGE >= STARVE_LIMIT).
  - Port 1 wins if P1_REQ && (!p0_req || FORCE); otherwise port 0 wins if p0_req.
- The winner's ADDR[ADDR_W-1:0], WDATA and write flag drive the MEM_* outputs, with MEM_EN=1.
  - With no winner: MEM_EN=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0.
- P1_GNT = port 1 wins. P0_STALL = p0_req && port 1 wins. P0_STALL is never asserted without a port 0 request.
- AGE register (0..STARVE_LIMIT, saturating):
  - Cleared when P1_REQ=0 or P1_GNT=1.
  - Otherwise increments.
- Arbitration states:
  - NORMAL (AGE < STARVE_LIMIT).
  - FORCED (AGE == STARVE_LIMIT): port 1 wins once, then AGE returns to 0 and the state returns to NORMAL.
- Read return: registered tag RD_OWNER in {NONE, P0, P1} is set on a granted read.
  - The following cycle, the owner's RVALID=1 and RDATA=MEM_RDATA. Latency is 1 cycle.
  - The non-owner's RDATA=0. Writes produce no RVALID.
- Back-to-back reads from alternating owners are legal every cycle. The tag pipeline is one entry deep and never blocks.
- A simultaneous port 0 store and port 1 read to the same address is resolved by arbitration only; there is no bypass.
- Reset, including mid-operation: AGE=0 and RD_OWNER=NONE. A pending read return is dropped (no RVALID the next cycle). All outputs are 0 while RESET=1 and the cycle after, except those derived combinationally from requests after reset deasserts.

Decomposition:
- Shared package dmem_pkg: OP_LOAD=2'b10, OP_STORE=2'b11, the owner encoding (NONE/P0/P1), and DATA_W/ADDR_W defaults.
- One sub-module, dmem_age_counter: saturating counter with clear, increment and FORCE output, parameterized by STARVE_LIMIT.

Test Plan:
- Reset, then port 0 store 0x1234 at 0x05, then port 0 load 0x05 -> MEM_WE=1 for one cycle, no stall; P0_RVALID=1 with P0_RDATA=0x1234 one cycle after the load.
- Idle port 0, P1_REQ read of 0x05 -> P1_GNT=1 same cycle; P1_RVALID=1, P1_RDATA=0x1234 next cycle; P0_RVALID stays 0.
- Port 0 loads every cycle with P1_REQ held (STARVE_LIMIT=4) -> P1_GNT=0 for 4 cycles; P1_GNT=1 and P0_STALL=1 in cycle 5; AGE=0 after.
- STARVE_LIMIT=0, simultaneous port 0 and port 1 requests -> port 1 always granted; P0_STALL=1 each such cycle.
- P0_ADDR=0x0085 store -> MEM_ADDR=0x05 (upper bits ignored).
- Port 1 read granted, RESET asserted the next cycle -> P1_RVALID never asserts; AGE=0, outputs 0.
